mult_div_unit: RTL and testbench

Multi-cycle HI/LO multiply/divide unit for the pipelined MIPS CPU. It sits beside the ALU in the EX stage and executes mult, multu, div and divu with configurable latency. It holds the architectural HI/LO registers, takes writes from mthi/mtlo, and raises `busy` so the hazard unit can stall dependent HI/LO instructions. It is the parametrised, sequential successor to the signed/unsigned operand-interpretation check used in earlier bring-up.

---
 rtl/mult_div_unit.sv | 133 +++++++++++++
 tb/tb_mult_div_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit for the EX stage.
// Operands are latched at launch and HI/LO commit after a fixed busy window.
module mult_div_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam int unsigned ProdW     = 2 * WIDTH;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;

  logic             is_signed;
  logic [ProdW-1:0] mul_a;
  logic [ProdW-1:0] mul_b;
  logic [ProdW-1:0] prod;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] b_safe;
  logic             div_zero;
  logic [WIDTH-1:0] uquot;
  logic [WIDTH-1:0] urem;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_d;

  // Result datapath from the latched operands; op_q[0] selects unsigned.
  always_comb begin
    is_signed = ~op_q[0];
    mul_a     = {{WIDTH{is_signed & a_q[WIDTH-1]}}, a_q};
    mul_b     = {{WIDTH{is_signed & b_q[WIDTH-1]}}, b_q};
    prod      = mul_a * mul_b;

    // Sign-magnitude divide: most-negative / -1 wraps back to most-negative with rem 0.
    a_neg     = is_signed & a_q[WIDTH-1];
    b_neg     = is_signed & b_q[WIDTH-1];
    a_mag     = a_neg ? (~a_q + WIDTH'(1)) : a_q;
    b_mag     = b_neg ? (~b_q + WIDTH'(1)) : b_q;
    div_zero  = (b_q == '0);
    b_safe    = div_zero ? WIDTH'(1) : b_mag;
    uquot     = a_mag / b_safe;
    urem      = a_mag % b_safe;
    quot      = (a_neg ^ b_neg) ? (~uquot + WIDTH'(1)) : uquot;
    rem       = a_neg ? (~urem + WIDTH'(1)) : urem;

    hi_d = prod[ProdW-1:WIDTH];
    lo_d = prod[WIDTH-1:0];
    if (op_q[1]) begin
      hi_d = div_zero ? hi_q : rem;
      lo_d = div_zero ? lo_q : quot;
    end
  end

  // Control FSM with the architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q    <= op;
            a_q     <= A;
            b_q     <= B;
            cnt_q   <= op[1] ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            if (hi_we) hi_q <= A;
            if (lo_we) lo_q <= A;
          end
        end
        S_RUN: begin
          if (cnt_q == CntW'(1)) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: default 32-bit instance plus a 16-bit fast instance,
// checked against an arithmetic reference model.
module tb_mult_div_unit;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        rst_v   [2];
  logic        start_v [2];
  logic [1:0]  op_v    [2];
  logic [31:0] a_v     [2];
  logic [31:0] b_v     [2];
  logic        hiwe_v  [2];
  logic        lowe_v  [2];
  logic        busy_o  [2];
  logic [31:0] hi_o    [2];
  logic [31:0] lo_o    [2];
  logic [31:0] ehi     [2];
  logic [31:0] elo     [2];

  logic [31:0] hi0_w, lo0_w;
  logic [15:0] hi1_w, lo1_w;
  logic        busy0_w, busy1_w;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mult_div_unit u_dut0 (
    .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .op(op_v[0]),
    .A(a_v[0]), .B(b_v[0]), .hi_we(hiwe_v[0]), .lo_we(lowe_v[0]),
    .busy(busy0_w), .HI(hi0_w), .LO(lo0_w)
  );

  mult_div_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) u_dut1 (
    .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .op(op_v[1]),
    .A(a_v[1][15:0]), .B(b_v[1][15:0]), .hi_we(hiwe_v[1]), .lo_we(lowe_v[1]),
    .busy(busy1_w), .HI(hi1_w), .LO(lo1_w)
  );

  assign busy_o[0] = busy0_w;
  assign busy_o[1] = busy1_w;
  assign hi_o[0]   = hi0_w;
  assign lo_o[0]   = lo0_w;
  assign hi_o[1]   = {16'h0, hi1_w};
  assign lo_o[1]   = {16'h0, lo1_w};

  function automatic int wid(input int d);
    return (d == 0) ? 32 : 16;
  endfunction

  function automatic int unsigned cycles(input int d, input logic [1:0] o);
    if (d == 0) return o[1] ? 10 : 5;
    return o[1] ? 3 : 1;
  endfunction

  function automatic logic [63:0] mask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Reference: integer arithmetic on sign- or zero-extended values, trimmed to w bits.
  function automatic void model(input int w, input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b, inout logic [31:0] hi, inout logic [31:0] lo);
    logic [63:0] m, ua, ub, p;
    longint      sa, sb, q, r;
    m  = mask(w);
    ua = {32'h0, a} & m;
    ub = {32'h0, b} & m;
    sa = ua[w-1] ? (longint'(ua) - longint'(64'd1 << w)) : longint'(ua);
    sb = ub[w-1] ? (longint'(ub) - longint'(64'd1 << w)) : longint'(ub);
    case (o)
      OP_MULT: begin
        p  = 64'(sa * sb);
        hi = 32'((p >> w) & m);
        lo = 32'(p & m);
      end
      OP_MULTU: begin
        p  = ua * ub;
        hi = 32'((p >> w) & m);
        lo = 32'(p & m);
      end
      OP_DIV: begin
        if (ub != 64'd0) begin
          q  = sa / sb;
          r  = sa % sb;
          lo = 32'(64'(q) & m);
          hi = 32'(64'(r) & m);
        end
      end
      default: begin
        if (ub != 64'd0) begin
          lo = 32'((ua / ub) & m);
          hi = 32'((ua % ub) & m);
        end
      end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int d, input logic s, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic hw, input logic lw);
    start_v[d] = s;
    op_v[d]    = o;
    a_v[d]     = a;
    b_v[d]     = b;
    hiwe_v[d]  = hw;
    lowe_v[d]  = lw;
  endtask

  task automatic mt(input int d, input logic hw, input logic lw, input logic [31:0] a);
    drv(d, 1'b0, 2'b00, a, 32'h0, hw, lw);
    tick();
    drv(d, 1'b0, 2'b00, $urandom, $urandom, 1'b0, 1'b0);
    if (hw) ehi[d] = a & 32'(mask(wid(d)));
    if (lw) elo[d] = a & 32'(mask(wid(d)));
    chk("mt_hi", hi_o[d], ehi[d]);
    chk("mt_lo", lo_o[d], elo[d]);
  endtask

  // Launch one op, optionally with mthi/mtlo in the same cycle or a mid-run intrusion.
  task automatic run_op(input int d, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic we, input logic inj);
    logic [31:0] nh, nl;
    int          n;
    nh = ehi[d];
    nl = elo[d];
    model(wid(d), o, a, b, nh, nl);
    drv(d, 1'b1, o, a, b, we, we);
    tick();
    drv(d, 1'b0, 2'($urandom), $urandom, $urandom, 1'b0, 1'b0);
    chk("launch_hold_hi", hi_o[d], ehi[d]);
    chk("launch_hold_lo", lo_o[d], elo[d]);
    n = 0;
    while (busy_o[d] === 1'b1 && n < 64) begin
      n++;
      if (inj && n == 2) drv(d, 1'b1, OP_DIVU, 32'd9, 32'd1, 1'b1, 1'b1);
      else if (inj && n == 3) drv(d, 1'b0, 2'b00, $urandom, $urandom, 1'b0, 1'b0);
      tick();
    end
    chk("busy_len", 32'(n), 32'(cycles(d, o)));
    ehi[d] = nh;
    elo[d] = nl;
    chk("result_hi", hi_o[d], ehi[d]);
    chk("result_lo", lo_o[d], elo[d]);
  endtask

  task automatic rand_op(input int d);
    logic [1:0]  o;
    logic [31:0] a, b;
    o = 2'($urandom_range(0, 3));
    a = $urandom;
    b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
    if ($urandom_range(0, 5) == 0) a = 32'h1 << (wid(d) - 1);
    if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFFF;
    run_op(d, o, a, b, 1'b0, 1'b0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_v[d] = 1'b1;
      drv(d, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
      ehi[d] = 32'h0;
      elo[d] = 32'h0;
    end
    tick();
    tick();
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("reset_busy", 32'(busy_o[d]), 32'h0);
      chk("reset_hi", hi_o[d], 32'h0);
      chk("reset_lo", lo_o[d], 32'h0);
    end

    run_op(0, OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("mult_m1_lo", lo_o[0], 32'h1);
    run_op(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("multu_max_hi", hi_o[0], 32'hFFFF_FFFE);
    run_op(0, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("div_neg7_lo", lo_o[0], 32'hFFFF_FFFD);
    run_op(0, OP_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("divu_lo", lo_o[0], 32'h7FFF_FFFC);
    run_op(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("div_ovf_lo", lo_o[0], 32'h8000_0000);
    chk("div_ovf_hi", hi_o[0], 32'h0);

    mt(0, 1'b1, 1'b0, 32'd5);
    mt(0, 1'b0, 1'b1, 32'd6);
    run_op(0, OP_DIV, 32'd123, 32'd0, 1'b0, 1'b0);
    chk("div0_hi_kept", hi_o[0], 32'd5);
    chk("div0_lo_kept", lo_o[0], 32'd6);

    // Intrusion mid-run is ignored, then a launch in the first idle cycle takes.
    run_op(0, OP_MULT, 32'd3, 32'd4, 1'b0, 1'b1);
    chk("busy_prot_lo", lo_o[0], 32'd12);
    run_op(0, OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0);
    chk("b2b_lo", lo_o[0], 32'd14);

    run_op(0, OP_MULT, 32'd7, 32'd3, 1'b1, 1'b0);
    chk("prio_lo", lo_o[0], 32'd21);
    mt(0, 1'b1, 1'b1, 32'h1234);

    // Reset in the third busy cycle of div 100/7 aborts the operation.
    drv(0, 1'b1, OP_DIV, 32'd100, 32'd7, 1'b0, 1'b0);
    tick();
    drv(0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk("pre_reset_busy", 32'(busy_o[0]), 32'h1);
    rst_v[0] = 1'b1;
    tick();
    rst_v[0] = 1'b0;
    ehi[0] = 32'h0;
    elo[0] = 32'h0;
    chk("midrst_busy", 32'(busy_o[0]), 32'h0);
    chk("midrst_hi", hi_o[0], 32'h0);
    chk("midrst_lo", lo_o[0], 32'h0);
    for (int i = 0; i < 12; i++) tick();
    chk("no_late_busy", 32'(busy_o[0]), 32'h0);
    chk("no_late_hi", hi_o[0], 32'h0);
    chk("no_late_lo", lo_o[0], 32'h0);

    for (int i = 0; i < 10; i++) rand_op(0);

    run_op(1, OP_DIV, 32'h8000, 32'hFFFF, 1'b0, 1'b0);
    chk("w16_ovf_lo", lo_o[1], 32'h8000);
    mt(1, 1'b1, 1'b1, 32'hABCD_5A5A);
    run_op(1, OP_DIVU, 32'h1, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) rand_op(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
